// File: rtl/wb_pull_fifo.sv
// Read-direction byte FIFO. A Wishbone controller port prefetches bytes from an
// upstream source, one single read at a time. A Wishbone device port pops one byte
// per accepted read from a downstream consumer.
module wb_pull_fifo #(
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  // Source (controller) port
  output logic                  src_cyc_o,
  output logic                  src_stb_o,
  output logic                  src_we_o,
  input  logic                  src_stall_i,
  input  logic                  src_ack_i,
  input  logic [7:0]            src_dat_i,
  // Consumer (device) port
  input  logic                  snk_cyc_i,
  input  logic                  snk_stb_i,
  input  logic                  snk_we_i,
  output logic                  snk_stall_o,
  output logic                  snk_ack_o,
  output logic [7:0]            snk_dat_o,
  // Status
  output logic [ADDR_WIDTH:0]   level_o,
  output logic                  empty_o,
  output logic                  full_o
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DepthCnt = (ADDR_WIDTH + 1)'(Depth);

  typedef enum logic [1:0] {StIdle, StReq, StWait} src_state_e;

  src_state_e            state_q;
  logic                  src_cyc_q, src_stb_q;
  logic [7:0]            mem_q [Depth];
  logic [ADDR_WIDTH-1:0] wptr_q, rptr_q;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  snk_ack_q;
  logic [7:0]            snk_dat_q;

  logic push, accept, pop;

  // Acks are only meaningful while a read is outstanding.
  assign push   = (state_q == StWait) & src_ack_i;
  assign accept = snk_cyc_i & snk_stb_i & ~snk_stall_o;
  assign pop    = accept & ~snk_we_i;

  assign empty_o     = (count_q == '0);
  assign full_o      = (count_q == DepthCnt);
  assign level_o     = count_q;
  assign snk_stall_o = empty_o;
  assign snk_ack_o   = snk_ack_q;
  assign snk_dat_o   = snk_dat_q;
  assign src_cyc_o   = src_cyc_q;
  assign src_stb_o   = src_stb_q;
  assign src_we_o    = 1'b0;

  // Occupancy next state: simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Source FSM with registered bus outputs; one read outstanding at a time.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      src_cyc_q <= 1'b0;
      src_stb_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // Starting at Depth-1 is safe: count can only fall during the fetch.
          if (count_q < DepthCnt) begin
            state_q   <= StReq;
            src_cyc_q <= 1'b1;
            src_stb_q <= 1'b1;
          end
        end
        StReq: begin
          if (!src_stall_i) begin
            state_q   <= StWait;
            src_stb_q <= 1'b0;
          end
        end
        StWait: begin
          if (src_ack_i) begin
            state_q   <= StIdle;
            src_cyc_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= StIdle;
          src_cyc_q <= 1'b0;
          src_stb_q <= 1'b0;
        end
      endcase
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Byte storage; contents are don't-care after reset.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= src_dat_i;
  end

  // Consumer response: one ack per accepted request, data only updated on a pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      snk_ack_q <= 1'b0;
      snk_dat_q <= '0;
    end else begin
      snk_ack_q <= accept;
      if (pop) snk_dat_q <= mem_q[rptr_q];
    end
  end

endmodule

// File: tb/tb_wb_pull_fifo.sv
// Bench for wb_pull_fifo at ADDR_WIDTH=2: a behavioural source device that acks one
// cycle after accepting with data A0+n, and a scoreboard of expected consumer bytes.
module tb_wb_pull_fifo;

  localparam int AW = 2;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          src_cyc_o, src_stb_o, src_we_o;
  logic          src_stall_i = 1'b0;
  logic          src_ack_i = 1'b0;
  logic [7:0]    src_dat_i = 8'h00;
  logic          snk_cyc_i = 1'b0, snk_stb_i = 1'b0, snk_we_i = 1'b0;
  logic          snk_stall_o, snk_ack_o;
  logic [7:0]    snk_dat_o;
  logic [AW:0]   level_o;
  logic          empty_o, full_o;

  wb_pull_fifo #(.ADDR_WIDTH(AW)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .src_cyc_o   (src_cyc_o),
    .src_stb_o   (src_stb_o),
    .src_we_o    (src_we_o),
    .src_stall_i (src_stall_i),
    .src_ack_i   (src_ack_i),
    .src_dat_i   (src_dat_i),
    .snk_cyc_i   (snk_cyc_i),
    .snk_stb_i   (snk_stb_i),
    .snk_we_i    (snk_we_i),
    .snk_stall_o (snk_stall_o),
    .snk_ack_o   (snk_ack_o),
    .snk_dat_o   (snk_dat_o),
    .level_o     (level_o),
    .empty_o     (empty_o),
    .full_o      (full_o)
  );

  always #5 clk_i = ~clk_i;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  bit         kind_q[$];
  logic [7:0] last_rd = 8'h00;
  int         rd_acks = 0;
  int         src_n = 0;
  bit         src_auto = 1'b1;
  bit         inject_ack = 1'b0;
  bit         req_seen = 1'b0;
  bit         mon_k;
  logic [7:0] mon_e;

  // Source device: sample the request mid-cycle, ack on the following cycle.
  always @(negedge clk_i) req_seen = rst_ni && src_cyc_o && src_stb_o && !src_stall_i;

  always @(posedge clk_i) begin
    #1;
    if (src_auto && req_seen) begin
      src_ack_i = 1'b1;
      src_dat_i = 8'hA0 + 8'(src_n);
      exp_q.push_back(src_dat_i);
      src_n++;
    end else if (inject_ack) begin
      src_ack_i = 1'b1;
      src_dat_i = 8'h55;
    end else begin
      src_ack_i = 1'b0;
    end
  end

  // Consumer monitor: match each ack to its request and check popped bytes in order.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (snk_ack_o) begin
        checks++;
        if (kind_q.size() == 0) begin
          errors++;
          $display("FAIL ack_unexpected: snk_ack_o=1 with no request outstanding");
        end else begin
          mon_k = kind_q.pop_front();
          if (!mon_k) begin
            rd_acks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL rd_data: got %h, scoreboard empty", snk_dat_o);
            end else begin
              mon_e = exp_q.pop_front();
              last_rd = mon_e;
              if (snk_dat_o !== mon_e) begin
                errors++;
                $display("FAIL rd_data: got %h expected %h", snk_dat_o, mon_e);
              end
            end
          end else if (snk_dat_o !== last_rd) begin
            errors++;
            $display("FAIL wr_ack_data: got %h expected %h", snk_dat_o, last_rd);
          end
        end
      end
      if (snk_cyc_i && snk_stb_i && !snk_stall_o) kind_q.push_back(snk_we_i);
    end
  end

  task automatic clear_sb();
    exp_q.delete();
    kind_q.delete();
    last_rd = 8'h00;
    rd_acks = 0;
    src_n = 0;
  endtask

  task automatic do_reset(input bit stall);
    @(posedge clk_i); #2;
    rst_ni = 1'b0;
    snk_cyc_i = 1'b0; snk_stb_i = 1'b0; snk_we_i = 1'b0;
    src_stall_i = stall;
    clear_sb();
    @(posedge clk_i); @(posedge clk_i); #2;
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    clear_sb();
    @(negedge clk_i);
    checks++; if (src_cyc_o !== 1'b0) begin errors++; $display("FAIL rst_cyc: got %b expected 0", src_cyc_o); end
    checks++; if (src_stb_o !== 1'b0) begin errors++; $display("FAIL rst_stb: got %b expected 0", src_stb_o); end
    checks++; if (src_we_o !== 1'b0) begin errors++; $display("FAIL rst_we: got %b expected 0", src_we_o); end
    checks++; if (snk_ack_o !== 1'b0) begin errors++; $display("FAIL rst_ack: got %b expected 0", snk_ack_o); end
    checks++; if (snk_dat_o !== 8'h00) begin errors++; $display("FAIL rst_dat: got %h expected 00", snk_dat_o); end
    checks++; if (level_o !== 3'd0) begin errors++; $display("FAIL rst_level: got %0d expected 0", level_o); end
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b expected 1", empty_o); end
    checks++; if (full_o !== 1'b0) begin errors++; $display("FAIL rst_full: got %b expected 0", full_o); end
    checks++; if (snk_stall_o !== 1'b1) begin errors++; $display("FAIL rst_stall: got %b expected 1", snk_stall_o); end
    @(posedge clk_i); #2;
    rst_ni = 1'b1;
  endtask

  task automatic test_fill();
    int prev = 0;
    bit mono = 1'b1;
    bit cyc_seen = 1'b0;
    for (int i = 0; i < 60 && !full_o; i++) begin
      @(negedge clk_i);
      if (int'(level_o) < prev || int'(level_o) > prev + 1) mono = 1'b0;
      prev = int'(level_o);
    end
    checks++; if (full_o !== 1'b1) begin errors++; $display("FAIL fill_full: got %b expected 1", full_o); end
    checks++; if (level_o !== 3'd4) begin errors++; $display("FAIL fill_level: got %0d expected 4", level_o); end
    checks++; if (mono !== 1'b1) begin errors++; $display("FAIL fill_steps: got %b expected 1", mono); end
    checks++; if (src_n != 4) begin errors++; $display("FAIL fill_fetches: got %0d expected 4", src_n); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      if (src_cyc_o) cyc_seen = 1'b1;
    end
    checks++; if (cyc_seen !== 1'b0) begin errors++; $display("FAIL full_cyc: got %b expected 0", cyc_seen); end
    @(posedge clk_i); #2;
    src_stall_i = 1'b1;
  endtask

  task automatic test_back_to_back();
    @(posedge clk_i); #2;
    snk_cyc_i = 1'b1; snk_stb_i = 1'b1; snk_we_i = 1'b0;
    @(negedge clk_i);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk_i);
      checks++;
      if (snk_ack_o !== 1'b1) begin errors++; $display("FAIL b2b_ack%0d: got %b expected 1", k, snk_ack_o); end
    end
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL b2b_empty: got %b expected 1", empty_o); end
    checks++; if (snk_stall_o !== 1'b1) begin errors++; $display("FAIL b2b_stall5: got %b expected 1", snk_stall_o); end
    @(posedge clk_i); #2;
    snk_cyc_i = 1'b0; snk_stb_i = 1'b0;
    @(negedge clk_i);
    checks++; if (snk_ack_o !== 1'b0) begin errors++; $display("FAIL b2b_no_ack5: got %b expected 0", snk_ack_o); end
    checks++; if (rd_acks != 4) begin errors++; $display("FAIL b2b_count: got %0d expected 4", rd_acks); end
  endtask

  task automatic test_src_stall();
    bit held = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      if (!(src_cyc_o && src_stb_o)) held = 1'b0;
    end
    checks++; if (held !== 1'b1) begin errors++; $display("FAIL stall_hold: got %b expected 1", held); end
    @(posedge clk_i); #2;
    src_stall_i = 1'b0;
    @(negedge clk_i);
    @(posedge clk_i); #2;
    src_stall_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if ({src_cyc_o, src_stb_o} !== 2'b10) begin
      errors++; $display("FAIL stall_wait: got cyc/stb %b%b expected 10", src_cyc_o, src_stb_o);
    end
    @(negedge clk_i);
    checks++; if (level_o !== 3'd1) begin errors++; $display("FAIL stall_land: got %0d expected 1", level_o); end
    repeat (4) @(negedge clk_i);
    checks++; if (level_o !== 3'd1) begin errors++; $display("FAIL stall_once: got %0d expected 1", level_o); end
    checks++; if (src_n != 5) begin errors++; $display("FAIL stall_fetches: got %0d expected 5", src_n); end
    @(posedge clk_i); #2;
    snk_cyc_i = 1'b1; snk_stb_i = 1'b1; snk_we_i = 1'b0;
    @(posedge clk_i); #2;
    snk_cyc_i = 1'b0; snk_stb_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    checks++; if (level_o !== 3'd0) begin errors++; $display("FAIL stall_drain: got %0d expected 0", level_o); end
  endtask

  task automatic test_wrap();
    bit found = 1'b0;
    do_reset(1'b0);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_i);
      if (src_cyc_o && src_stb_o && !src_stall_i && level_o == 3'd3) begin
        found = 1'b1;
        break;
      end
    end
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL wrap_setup: got %b expected 1", found); end
    @(posedge clk_i); #2;
    snk_cyc_i = 1'b1; snk_stb_i = 1'b1; snk_we_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if ({src_ack_i, snk_stall_o} !== 2'b10) begin
      errors++; $display("FAIL wrap_simul: got ack/stall %b%b expected 10", src_ack_i, snk_stall_o);
    end
    @(negedge clk_i);
    checks++; if (level_o !== 3'd3) begin errors++; $display("FAIL wrap_level: got %0d expected 3", level_o); end
    for (int i = 0; i < 200; i++) begin
      @(posedge clk_i); #2;
      if (src_n >= 8) src_stall_i = 1'b1;
      if (rd_acks >= 8) break;
    end
    snk_cyc_i = 1'b0; snk_stb_i = 1'b0;
    repeat (2) @(negedge clk_i);
    checks++; if (rd_acks != 8) begin errors++; $display("FAIL wrap_reads: got %0d expected 8", rd_acks); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_left: got %0d expected 0", exp_q.size()); end
    checks++; if (level_o !== 3'd0) begin errors++; $display("FAIL wrap_empty: got %0d expected 0", level_o); end
  endtask

  task automatic test_write();
    @(posedge clk_i); #2;
    src_stall_i = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk_i); #2;
      if (level_o == 3'd2) begin
        src_stall_i = 1'b1;
        break;
      end
    end
    checks++; if (level_o !== 3'd2) begin errors++; $display("FAIL wr_setup: got %0d expected 2", level_o); end
    @(posedge clk_i); #2;
    snk_cyc_i = 1'b1; snk_stb_i = 1'b1; snk_we_i = 1'b1;
    @(posedge clk_i); #2;
    snk_cyc_i = 1'b0; snk_stb_i = 1'b0; snk_we_i = 1'b0;
    @(negedge clk_i);
    checks++; if (snk_ack_o !== 1'b1) begin errors++; $display("FAIL wr_ack: got %b expected 1", snk_ack_o); end
    checks++; if (snk_dat_o !== 8'hA7) begin errors++; $display("FAIL wr_dat_hold: got %h expected a7", snk_dat_o); end
    checks++; if (level_o !== 3'd2) begin errors++; $display("FAIL wr_level: got %0d expected 2", level_o); end
    @(negedge clk_i);
    checks++; if (snk_ack_o !== 1'b0) begin errors++; $display("FAIL wr_pulse: got %b expected 0", snk_ack_o); end
  endtask

  task automatic test_reset_wait();
    bit in_wait = 1'b0;
    src_auto = 1'b0;
    @(posedge clk_i); #2;
    src_stall_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (src_cyc_o && !src_stb_o) begin
        in_wait = 1'b1;
        break;
      end
    end
    checks++; if (in_wait !== 1'b1) begin errors++; $display("FAIL rw_setup: got %b expected 1", in_wait); end
    #1;
    rst_ni = 1'b0;
    src_stall_i = 1'b1;
    inject_ack = 1'b1;
    clear_sb();
    #1;
    checks++; if (src_cyc_o !== 1'b0) begin errors++; $display("FAIL rw_cyc_drop: got %b expected 0", src_cyc_o); end
    checks++; if (level_o !== 3'd0) begin errors++; $display("FAIL rw_level: got %0d expected 0", level_o); end
    @(posedge clk_i); #2;
    rst_ni = 1'b1;
    @(posedge clk_i); #2;
    inject_ack = 1'b0;
    repeat (2) @(negedge clk_i);
    checks++; if (level_o !== 3'd0) begin errors++; $display("FAIL rw_late_ack: got %0d expected 0", level_o); end
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL rw_empty: got %b expected 1", empty_o); end
    src_auto = 1'b1;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_back_to_back();
    test_src_stall();
    test_wrap();
    test_write();
    test_reset_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
